// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped, one-word-per-line instruction cache with single-miss refill
module icache #(
  parameter int INDEX_WIDTH = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        if2iCache_enable,
  input  logic [31:0] if2iCache_addr,
  output logic        iCache2if_enable,
  output logic [31:0] iCache2if_inst,
  output logic        iCache2memCon_enable,
  output logic [31:0] iCache2memCon_adderss,
  input  logic        memCon2iCache_enable,
  input  logic [31:0] memCon2iCache_return
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 32 - INDEX_WIDTH - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t state, state_next;

  logic [LINES-1:0]       valid;
  logic [TAG_W-1:0]       tags [LINES];
  logic [31:0]            data [LINES];
  logic                   miss_cleared;

  logic [INDEX_WIDTH-1:0] req_index, miss_index;
  logic [TAG_W-1:0]       req_tag, miss_tag;
  logic                   hit, start_miss, fill;

  assign req_index  = if2iCache_addr[INDEX_WIDTH+1:2];
  assign req_tag    = if2iCache_addr[31:INDEX_WIDTH+2];
  assign miss_index = iCache2memCon_adderss[INDEX_WIDTH+1:2];
  assign miss_tag   = iCache2memCon_adderss[31:INDEX_WIDTH+2];

  // A clear in the same cycle invalidates before lookup, so it forces a miss.
  assign hit = valid[req_index] && (tags[req_index] == req_tag) && !clear_in;

  always_comb begin
    state_next = state;
    start_miss = 1'b0;
    fill       = 1'b0;
    case (state)
      IDLE: if (if2iCache_enable && !hit) begin
        state_next = MISS;
        start_miss = 1'b1;
      end
      MISS: if (memCon2iCache_enable) begin
        state_next = IDLE;
        fill       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else if (rdy_in) state <= state_next;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid                 <= '0;
      miss_cleared          <= 1'b0;
      iCache2if_enable      <= 1'b0;
      iCache2if_inst        <= '0;
      iCache2memCon_enable  <= 1'b0;
      iCache2memCon_adderss <= '0;
    end else if (rdy_in) begin
      iCache2if_enable <= 1'b0;
      if (clear_in) valid <= '0;
      if (state == IDLE && if2iCache_enable && hit) begin
        iCache2if_enable <= 1'b1;
        iCache2if_inst   <= data[req_index];
      end
      if (start_miss) begin
        iCache2memCon_enable  <= 1'b1;
        iCache2memCon_adderss <= {if2iCache_addr[31:2], 2'b00};
        miss_cleared          <= 1'b0;
      end
      if (state == MISS && clear_in) miss_cleared <= 1'b1;
      // A clear seen anywhere in this miss leaves the refilled line invalid.
      if (fill) begin
        iCache2if_enable     <= 1'b1;
        iCache2if_inst       <= memCon2iCache_return;
        iCache2memCon_enable <= 1'b0;
        if (!clear_in && !miss_cleared) valid[miss_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && fill) begin
      data[miss_index] <= memCon2iCache_return;
      tags[miss_index] <= miss_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache: transaction model plus directed literal checks
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        if_en;
  logic [31:0] inst;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic        ret_en = 1'b0;
  logic [31:0] ret = '0;

  int errors = 0;
  int checks = 0;

  icache dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clear),
    .if2iCache_enable(req), .if2iCache_addr(addr),
    .iCache2if_enable(if_en), .iCache2if_inst(inst),
    .iCache2memCon_enable(mem_en), .iCache2memCon_adderss(mem_addr),
    .memCon2iCache_enable(ret_en), .memCon2iCache_return(ret)
  );

  always #5 clk = ~clk;

  // Model: the cache as a table of remembered word addresses, plus "a refill is pending".
  bit          m_valid [64];
  int unsigned m_word  [64];
  logic [31:0] m_data  [64];
  bit          busy, busy_cleared;
  int unsigned pend_word;
  logic        e_if_en, e_mem_en;
  logic [31:0] e_inst, e_mem_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      busy = 0; busy_cleared = 0;
      e_if_en = 0; e_inst = 0; e_mem_en = 0; e_mem_addr = 0;
    end else if (rdy) begin
      e_if_en = 0;
      if (clear) begin
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        if (busy) busy_cleared = 1;
      end
      if (busy) begin
        if (ret_en) begin
          if (!busy_cleared) begin
            m_valid[pend_word % 64] = 1'b1;
            m_word[pend_word % 64]  = pend_word;
            m_data[pend_word % 64]  = ret;
          end
          e_if_en = 1; e_inst = ret; e_mem_en = 0; busy = 0;
        end
      end else if (req) begin
        int unsigned w;
        w = addr / 4;
        if (m_valid[w % 64] && m_word[w % 64] == w) begin
          e_if_en = 1; e_inst = m_data[w % 64];
        end else begin
          busy = 1; busy_cleared = 0; pend_word = w;
          e_mem_en = 1; e_mem_addr = w * 4;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model if_en", {31'b0, if_en}, {31'b0, e_if_en});
      chk("model mem_en", {31'b0, mem_en}, {31'b0, e_mem_en});
      if (e_mem_en) chk("model mem_addr", mem_addr, e_mem_addr);
      if (e_if_en) chk("model inst", inst, e_inst);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] a);
    req = 1'b1; addr = a;
    tick();
    req = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic clr);
    ret_en = 1'b1; ret = d; clear = clr;
    tick();
    ret_en = 1'b0; clear = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset if_en", {31'b0, if_en}, 32'd0);
    chk("reset inst", inst, 32'd0);
    chk("reset mem_en", {31'b0, mem_en}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    @(posedge clk); #2; rst = 1'b0;

    // Cold miss then fill
    fetch(32'h0000_1004);
    chk("cold mem_en", {31'b0, mem_en}, 32'd1);
    chk("cold mem_addr", mem_addr, 32'h0000_1004);
    chk("cold no if_en", {31'b0, if_en}, 32'd0);
    tick();
    chk("miss holds addr", mem_addr, 32'h0000_1004);
    respond(32'h00A0_0093, 1'b0);
    chk("fill if_en", {31'b0, if_en}, 32'd1);
    chk("fill inst", inst, 32'h00A0_0093);
    chk("fill mem_en low", {31'b0, mem_en}, 32'd0);

    // Hit with unaligned low bits, then back-to-back hit
    req = 1'b1; addr = 32'h0000_1006;
    tick();
    chk("hit if_en", {31'b0, if_en}, 32'd1);
    chk("hit inst", inst, 32'h00A0_0093);
    chk("hit no mem", {31'b0, mem_en}, 32'd0);
    addr = 32'h0000_1004;
    tick();
    req = 1'b0;
    chk("b2b hit if_en", {31'b0, if_en}, 32'd1);
    tick();
    chk("idle if_en low", {31'b0, if_en}, 32'd0);

    // Conflict on the same index
    fetch(32'h0000_1104);
    chk("conflict mem_addr", mem_addr, 32'h0000_1104);
    fetch(32'h0000_3000);
    chk("req in miss ignored", mem_addr, 32'h0000_1104);
    respond(32'h1234_5678, 1'b0);
    chk("conflict inst", inst, 32'h1234_5678);
    fetch(32'h0000_1004);
    chk("evicted misses", {31'b0, mem_en}, 32'd1);
    respond(32'h00A0_0093, 1'b0);

    // Clear in idle, then clear with request in same cycle
    clear = 1'b1; tick(); clear = 1'b0;
    fetch(32'h0000_1004);
    chk("after clear misses", {31'b0, mem_en}, 32'd1);
    respond(32'h00A0_0093, 1'b0);
    clear = 1'b1; fetch(32'h0000_1004); clear = 1'b0;
    chk("clear+req misses", {31'b0, mem_en}, 32'd1);
    // Clear mid-miss: delivered but not retained
    clear = 1'b1; tick(); clear = 1'b0;
    respond(32'h00A0_0093, 1'b0);
    chk("cleared miss delivered", inst, 32'h00A0_0093);
    fetch(32'h0000_1004);
    chk("cleared miss not kept", {31'b0, mem_en}, 32'd1);
    // Clear exactly on the response edge
    respond(32'h00A0_0093, 1'b1);
    chk("edge clear delivered", {31'b0, if_en}, 32'd1);
    fetch(32'h0000_1004);
    chk("edge clear not kept", {31'b0, mem_en}, 32'd1);
    respond(32'h00A0_0093, 1'b0);
    fetch(32'h0000_1004);
    chk("refill kept", {31'b0, if_en}, 32'd1);

    // Stall with response pending
    fetch(32'h0000_2008);
    rdy = 1'b0; ret_en = 1'b1; ret = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall if_en", {31'b0, if_en}, 32'd0);
      chk("stall mem_en", {31'b0, mem_en}, 32'd1);
    end
    rdy = 1'b1;
    tick();
    ret_en = 1'b0;
    chk("stall release if_en", {31'b0, if_en}, 32'd1);
    chk("stall release inst", inst, 32'hDEAD_BEEF);
    chk("stall release mem_en", {31'b0, mem_en}, 32'd0);

    // Async reset mid-miss
    fetch(32'h0000_4000);
    chk("pre-reset mem_en", {31'b0, mem_en}, 32'd1);
    #1 rst = 1'b1;
    #1 chk("async reset mem_en", {31'b0, mem_en}, 32'd0);
    tick();
    rst = 1'b0;
    respond(32'h5555_AAAA, 1'b0);
    chk("stale response ignored", {31'b0, if_en}, 32'd0);
    tick();
    chk("still idle", {31'b0, if_en}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
